lfsr_stream: RTL and testbench

- Parametrised successor to the fixed 8-bit free-running LFSR: Fibonacci LFSR with configurable width, tap mask and reset seed.
- Exposes each state word on a valid/ready output stream, so words advance only when consumed.
- Adds a runtime seed load and all-zero lock-up recovery.
- Used as a pattern/scrambler source in benches and datapaths that can apply backpressure.

---
 rtl/lfsr_pkg.sv | 53 +++++
 rtl/lfsr_period_mon.sv | 64 ++++++
 rtl/lfsr_stream.sv | 83 ++++++++
 tb/tb_lfsr_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default seed, maximal-length tap masks for widths 3..32,
// and the Fibonacci step function used as the common reference model.
package lfsr_pkg;

    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h8A;
    localparam int         LFSR_W_MIN        = 3;
    localparam int         LFSR_W_MAX        = 32;

    // Bit i of a mask feeds state[i] into the XOR; every entry is a maximal polynomial.
    function automatic logic [31:0] lfsr_default_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_00B8;
        endcase
        return taps;
    endfunction

    // Operands are zero-extended to 32 bits; the caller keeps the low WIDTH bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        return {state[30:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// Period monitor: counts accepted steps and flags the return to the start word.
// Built only when LFSR_PERIOD_CHK_EN is defined.
module lfsr_period_mon
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_word_i,
    input  logic [WIDTH-1:0] next_i,
    output logic             period_done_o,
    output logic [WIDTH-1:0] period_len_o
);

    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] cnt_inc;

    // Saturate rather than wrap so a runaway count never aliases a short period.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        start_d = start_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (load_i) begin
            start_d = load_word_i;
            cnt_d   = '0;
        end else if (accept_i) begin
            if (next_i == start_q) begin
                done_d = 1'b1;
                len_d  = cnt_inc;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= SEED;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    assign period_done_o = done_q;
    assign period_len_o  = len_q;

endmodule

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR presented as a valid/ready stream, with runtime seed load and
// all-zero lock-up recovery. Optional period monitor under LFSR_PERIOD_CHK_EN.
module lfsr_stream
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_seed,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             valid_q;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] load_word;
    logic             accept;
    logic             zero_load;

    assign next_word = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    assign accept    = valid_q & out_ready & en;
    // An all-zero state would stick forever, so a zero load is replaced by SEED.
    assign zero_load = load_valid & (load_seed == '0);
    assign load_word = (load_seed == '0) ? SEED : load_seed;

    always_comb begin
        state_d  = state_q;
        lockup_d = 1'b0;
        if (load_valid) begin
            state_d  = load_word;
            lockup_d = zero_load;
        end else if (accept) begin
            state_d  = next_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            valid_q  <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= en;
            lockup_q <= lockup_d;
        end
    end

    assign out_data  = state_q;
    assign out_valid = valid_q;
    assign lockup    = lockup_q;

`ifdef LFSR_PERIOD_CHK_EN
    lfsr_period_mon #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_mon (
        .clk           (clk),
        .reset         (reset),
        .accept_i      (accept),
        .load_i        (load_valid),
        .load_word_i   (load_word),
        .next_i        (next_word),
        .period_done_o (period_done),
        .period_len_o  (period_len)
    );
`else
    assign period_done = 1'b0;
    assign period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: an 8-bit default instance and a 4-bit (TAPS=4'hC,
// SEED=4'h1) instance; period checks adapt to LFSR_PERIOD_CHK_EN.
module tb_lfsr_stream;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       reset, en, out_ready, load_valid;
    logic [7:0] load_seed, out_data, period_len;
    logic       out_valid, lockup, period_done;

    // 4-bit instance
    logic       r4, en4, rdy4, ld4;
    logic [3:0] seed4, data4, len4;
    logic       valid4, lock4, done4;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_stream dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .load_valid  (load_valid),
        .load_seed   (load_seed),
        .lockup      (lockup),
        .period_done (period_done),
        .period_len  (period_len)
    );

    lfsr_stream #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut4 (
        .clk         (clk),
        .reset       (r4),
        .en          (en4),
        .out_data    (data4),
        .out_valid   (valid4),
        .out_ready   (rdy4),
        .load_valid  (ld4),
        .load_seed   (seed4),
        .lockup      (lock4),
        .period_done (done4),
        .period_len  (len4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 255 accepts from the seed must return to 0x8A exactly at the last one.
    task automatic run_period8(input string tag);
        int first_ret = 0;
        int pulses    = 0;
        int pulse_at  = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (out_data == 8'h8A && first_ret == 0) first_ret = i;
            if (period_done) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk({tag, "_return_step"}, first_ret, 255);
        chk({tag, "_data_end"}, out_data, 8'h8A);
`ifdef LFSR_PERIOD_CHK_EN
        chk({tag, "_done_pulses"}, pulses, 1);
        chk({tag, "_done_at"}, pulse_at, 255);
        chk({tag, "_len"}, period_len, 255);
`else
        chk({tag, "_done_pulses"}, pulses, 0);
        chk({tag, "_len"}, period_len, 0);
`endif
    endtask

    logic [3:0] exp4 [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    initial begin
        reset = 1'b1; en = 1'b0; out_ready = 1'b0; load_valid = 1'b0; load_seed = 8'h00;
        r4 = 1'b1; en4 = 1'b0; rdy4 = 1'b0; ld4 = 1'b0; seed4 = 4'h0;

        // Reset state
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h8A);
        chk("rst_lockup", lockup, 0);
        chk("rst_done", period_done, 0);
        chk("rst_len", period_len, 0);

        // First words
        reset = 1'b0; en = 1'b1; out_ready = 1'b1;
        step();
        chk("first_valid", out_valid, 1);
        chk("first_w0", out_data, 8'h8A);
        step();
        chk("first_w1", out_data, 8'h14);

        // Backpressure via out_ready
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", out_data, 8'h14);
            chk("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", out_data, 8'h29);

        // Hold via en
        en = 1'b0;
        step();
        chk("en_off_valid", out_valid, 0);
        chk("en_off_hold", out_data, 8'h29);
        step();
        chk("en_off_hold2", out_data, 8'h29);
        en = 1'b1;
        step();
        chk("en_on_valid", out_valid, 1);
        chk("en_on_hold", out_data, 8'h29);
        step();
        chk("en_on_next", out_data, 8'h52);

        // Load while accepting
        load_valid = 1'b1; load_seed = 8'h01;
        step();
        load_valid = 1'b0;
        chk("load_data", out_data, 8'h01);
        chk("load_lockup", lockup, 0);
        chk("load_valid_kept", out_valid, 1);
        step();
        chk("load_next", out_data, 8'h02);
        chk("load_lockup2", lockup, 0);

        // Lock-up recovery on zero load
        load_valid = 1'b1; load_seed = 8'h00;
        step();
        load_valid = 1'b0; out_ready = 1'b0;
        chk("lock_data", out_data, 8'h8A);
        chk("lock_pulse", lockup, 1);
        step();
        chk("lock_pulse_end", lockup, 0);
        chk("lock_hold", out_data, 8'h8A);

        // Full period from reset
        reset = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b1;
        step();
        run_period8("period8");

        // Reset mid-stream after 20 accepts
        for (int i = 0; i < 20; i++) step();
        chk("mid_not_seed", (out_data == 8'h8A), 0);
        reset = 1'b1; load_valid = 1'b1; load_seed = 8'h33;
        step();
        reset = 1'b0; load_valid = 1'b0;
        chk("mid_rst_data", out_data, 8'h8A);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", period_done, 0);
        chk("mid_rst_len", period_len, 0);
        step();
        chk("mid_valid", out_valid, 1);
        chk("mid_w0", out_data, 8'h8A);
        run_period8("period8_after_rst");

        // 4-bit instance: full 15-step sequence
        en = 1'b0;
        r4 = 1'b0; en4 = 1'b1; rdy4 = 1'b1;
        step();
        chk("w4_valid", valid4, 1);
        chk("w4_seed", data4, 4'h1);
        begin
            int pulses4 = 0;
            int at4     = 0;
            for (int i = 0; i < 15; i++) begin
                step();
                chk($sformatf("w4_step%0d", i + 1), data4, exp4[i]);
                if (done4) begin
                    pulses4++;
                    at4 = i + 1;
                end
            end
`ifdef LFSR_PERIOD_CHK_EN
            chk("w4_done_pulses", pulses4, 1);
            chk("w4_done_at", at4, 15);
            chk("w4_len", len4, 15);
`else
            chk("w4_done_pulses", pulses4, 0);
            chk("w4_len", len4, 0);
`endif
        end
        chk("w4_lockup", lock4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
